// File: rtl/fp_adder_arbiter_if.sv
// Bus bundle for fp_adder_arbiter.
// Groups the requester handshake, the adder-side signals and the status outputs.
//   slave  : arbiter view (requests and adder results in; grants, adder drive and responses out)
//   master : environment view (requesters plus the adder), the mirror image of slave
// Requester i uses bits [16i+15:16i] of req_a/req_b.
interface fp_adder_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  add_en;
  logic [15:0]           add_dataa;
  logic [15:0]           add_datab;
  logic [15:0]           add_result;
  logic                  add_sign;
  logic                  add_overflow;
  logic                  add_underflow;

  logic [NUM_REQ-1:0]    resp_valid;
  logic [15:0]           resp_data;
  logic                  resp_sign;
  logic                  resp_overflow;
  logic                  resp_underflow;

  logic                  busy;
  logic [15:0]           op_count;

  modport slave (
    input  req_valid, req_a, req_b,
    input  add_result, add_sign, add_overflow, add_underflow,
    output req_ready,
    output add_en, add_dataa, add_datab,
    output resp_valid, resp_data, resp_sign, resp_overflow, resp_underflow,
    output busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b,
    output add_result, add_sign, add_overflow, add_underflow,
    input  req_ready,
    input  add_en, add_dataa, add_datab,
    input  resp_valid, resp_data, resp_sign, resp_overflow, resp_underflow,
    input  busy, op_count
  );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one sequential fp16 adder among NUM_REQ requesters.
// One operand pair is accepted at a time: the winner's operands are registered, the adder's
// clk_en is pulsed for one cycle, the arbiter waits ADD_LATENCY cycles, captures result and
// flags, and returns them to the owner with a one-hot, one-cycle resp_valid pulse.
// Ports:
//   clk_i  : system clock, posedge
//   rst_i  : asynchronous active-high reset; abandons any in-flight operation
//   bus_io : fp_adder_arbiter_if.slave (requests, adder interface, responses, busy, op_count)
// Timing: grant in cycle T, add_en in T+1, resp_valid in T+ADD_LATENCY+3.
module fp_adder_arbiter #(
  parameter int unsigned  NUM_REQ     = 4,
  parameter int unsigned  ADD_LATENCY = 4,
  localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fp_adder_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StArb, StIssue, StWait, StCapture} state_e;

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    owner_q;
  logic [3:0]         cnt_q;
  logic               add_en_q;
  logic [15:0]        dataa_q;
  logic [15:0]        datab_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [15:0]        resp_data_q;
  logic               resp_sign_q;
  logic               resp_overflow_q;
  logic               resp_underflow_q;
  logic [15:0]        op_count_q;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] req_ready;
  logic [15:0]        req_a_arr [NUM_REQ];
  logic [15:0]        req_b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_unpack
    assign req_a_arr[g] = bus_io.req_a[16*g +: 16];
    assign req_b_arr[g] = bus_io.req_b[16*g +: 16];
  end

  // Scan from ptr+1 upward with wrap; the last granted requester is checked last.
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && bus_io.req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StArb && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= StArb;
      ptr_q            <= ID_W'(NUM_REQ - 1);
      owner_q          <= '0;
      cnt_q            <= '0;
      add_en_q         <= 1'b0;
      dataa_q          <= '0;
      datab_q          <= '0;
      resp_valid_q     <= '0;
      resp_data_q      <= '0;
      resp_sign_q      <= 1'b0;
      resp_overflow_q  <= 1'b0;
      resp_underflow_q <= 1'b0;
      op_count_q       <= '0;
    end else begin
      // Both strobes are single-cycle pulses unless re-armed below.
      resp_valid_q <= '0;
      add_en_q     <= 1'b0;
      unique case (state_q)
        StArb: begin
          if (grant_found) begin
            dataa_q  <= req_a_arr[grant_idx];
            datab_q  <= req_b_arr[grant_idx];
            owner_q  <= grant_idx;
            ptr_q    <= grant_idx;
            add_en_q <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= 4'd1;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'(ADD_LATENCY)) begin
            // The adder output is only guaranteed in this last wait cycle, so sample it here.
            resp_data_q      <= bus_io.add_result;
            resp_sign_q      <= bus_io.add_sign;
            resp_overflow_q  <= bus_io.add_overflow;
            resp_underflow_q <= bus_io.add_underflow;
            state_q          <= StCapture;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StCapture: begin
          resp_valid_q[owner_q] <= 1'b1;
          if (op_count_q != 16'hFFFF) begin
            op_count_q <= op_count_q + 16'd1;
          end
          state_q <= StArb;
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign bus_io.req_ready      = req_ready;
  assign bus_io.add_en         = add_en_q;
  assign bus_io.add_dataa      = dataa_q;
  assign bus_io.add_datab      = datab_q;
  assign bus_io.resp_valid     = resp_valid_q;
  assign bus_io.resp_data      = resp_data_q;
  assign bus_io.resp_sign      = resp_sign_q;
  assign bus_io.resp_overflow  = resp_overflow_q;
  assign bus_io.resp_underflow = resp_underflow_q;
  assign bus_io.busy           = (state_q != StArb);
  assign bus_io.op_count       = op_count_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Self-checking bench for fp_adder_arbiter: directed steps plus random operands, checked
// against a cycle-numbered reference of the arbitration rules and a real-valued fp16 adder.
module tb_fp_adder_arbiter;
  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned ADD_LATENCY = 4;
  localparam int          RESP_LAT    = ADD_LATENCY + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_adder_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  fp_adder_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADD_LATENCY(ADD_LATENCY)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- fp16 helpers (normals, flush-to-zero on tiny results) ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    m = real'(h[9:0]) / 1024.0;
    if (e == 0) m = m * pow2(-14);
    else        m = (1.0 + m) * pow2(e - 15);
    return h[15] ? -m : m;
  endfunction

  // Returns {underflow, overflow, sign, fp16}.
  function automatic logic [18:0] real_to_fp16(input real x);
    real         m;
    int          e;
    int          frac;
    logic        s;
    logic        ov;
    logic        un;
    logic [15:0] h;
    s  = (x < 0.0);
    m  = s ? -x : x;
    ov = 1'b0;
    un = 1'b0;
    if (m == 0.0) begin
      h = 16'h0000;
    end else if (m >= 65520.0) begin
      h  = {s, 15'h7C00};
      ov = 1'b1;
    end else if (m < pow2(-14)) begin
      h  = {s, 15'h0000};
      un = 1'b1;
    end else begin
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      frac = $rtoi((m - 1.0) * 1024.0 + 0.5);
      h    = {s, 5'(e + 15), 10'(frac)};
    end
    return {un, ov, h[15], h};
  endfunction

  function automatic logic [18:0] fp16_add_model(input logic [15:0] a, input logic [15:0] b);
    return real_to_fp16(fp16_to_real(a) + fp16_to_real(b));
  endfunction

  function automatic logic [15:0] rand_op();
    logic [18:0] r;
    r = real_to_fp16(real'(int'($urandom_range(0, 200)) - 100));
    return r[15:0];
  endfunction

  // ---------------- adder model: result valid exactly ADD_LATENCY cycles after clk_en ----------
  int          pend_cyc = -1;
  logic [15:0] pend_a;
  logic [15:0] pend_b;
  always @(negedge clk) begin : adder_model
    logic [18:0] r;
    if (bus.add_en === 1'b1) begin
      pend_cyc = cyc + int'(ADD_LATENCY);
      pend_a   = bus.add_dataa;
      pend_b   = bus.add_datab;
    end
    if (cyc == pend_cyc) begin
      r = fp16_add_model(pend_a, pend_b);
      {bus.add_underflow, bus.add_overflow, bus.add_sign, bus.add_result} = r;
    end else begin
      // Junk outside the valid cycle exposes mistimed capture.
      bus.add_result    = 16'($urandom);
      bus.add_sign      = 1'($urandom);
      bus.add_overflow  = 1'($urandom);
      bus.add_underflow = 1'($urandom);
    end
  end

  // ---------------- requesters and reference model ----------------
  typedef struct {
    int          cyc;
    int          owner;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic [15:0] opa [NUM_REQ];
  logic [15:0] opb [NUM_REQ];
  int          ops_left [NUM_REQ];
  exp_t        exp_q [$];
  int          obs_g [$];
  int          obs_c [$];
  int          m_ptr;
  int          m_last_grant;
  int          m_free;
  int          m_count;
  logic [15:0] m_issue_a;
  logic [15:0] m_issue_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_ptr        = NUM_REQ - 1;
    m_last_grant = -1;
    m_free       = 0;
    m_count      = 0;
    exp_q.delete();
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]      = (ops_left[i] > 0);
      bus.req_a[16*i +: 16] = opa[i];
      bus.req_b[16*i +: 16] = opb[i];
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() > 0);
    for (int i = 0; i < NUM_REQ; i++) if (ops_left[i] > 0) p = 1'b1;
    return p;
  endfunction

  // One clock cycle: drive, check at negedge, advance model and requesters.
  task automatic step();
    logic [NUM_REQ-1:0] want_ready;
    logic [NUM_REQ-1:0] want_resp;
    logic [18:0]        r;
    exp_t               e;
    int                 win;
    int                 j;
    int                 c;
    bit                 issue;
    drive_reqs();
    @(negedge clk);
    c         = cyc;
    want_resp = '0;
    if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
      e = exp_q.pop_front();
      r = fp16_add_model(e.a, e.b);
      want_resp[e.owner] = 1'b1;
      if (m_count < 16'hFFFF) m_count++;
      check("resp_data", 32'(bus.resp_data), 32'(r[15:0]));
      check("resp_sign", 32'(bus.resp_sign), 32'(r[16]));
      check("resp_overflow", 32'(bus.resp_overflow), 32'(r[17]));
      check("resp_underflow", 32'(bus.resp_underflow), 32'(r[18]));
      check("op_count", 32'(bus.op_count), 32'(m_count));
    end
    check("resp_valid", 32'(bus.resp_valid), 32'(want_resp));
    check("busy", 32'(bus.busy), 32'(m_last_grant >= 0 && c > m_last_grant && c < m_free));
    issue = (m_last_grant >= 0 && c == m_last_grant + 1);
    check("add_en", 32'(bus.add_en), 32'(issue));
    if (issue) begin
      check("add_dataa", 32'(bus.add_dataa), 32'(m_issue_a));
      check("add_datab", 32'(bus.add_datab), 32'(m_issue_b));
    end
    win        = -1;
    want_ready = '0;
    if (c >= m_free) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        j = (m_ptr + k) % NUM_REQ;
        if (win < 0 && ops_left[j] > 0) win = j;
      end
    end
    if (win >= 0) begin
      want_ready[win] = 1'b1;
      e.cyc   = c + RESP_LAT;
      e.owner = win;
      e.a     = opa[win];
      e.b     = opb[win];
      exp_q.push_back(e);
      m_issue_a    = opa[win];
      m_issue_b    = opb[win];
      m_ptr        = win;
      m_last_grant = c;
      m_free       = c + RESP_LAT;
    end
    check("req_ready", 32'(bus.req_ready), 32'(want_ready));
    if (bus.req_ready != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) j = i;
      obs_g.push_back(j);
      obs_c.push_back(c);
    end
    if (win >= 0) begin
      ops_left[win]--;
      if (ops_left[win] > 0) begin
        opa[win] = rand_op();
        opb[win] = rand_op();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int max_steps);
    int n;
    n = 0;
    while (pending() && n < max_steps) begin
      step();
      n++;
    end
    check("idle_within_budget", 32'(n < max_steps), 32'd1);
    repeat (2) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":add_en"}, 32'(bus.add_en), 32'd0);
    check({tag, ":add_dataa"}, 32'(bus.add_dataa), 32'd0);
    check({tag, ":add_datab"}, 32'(bus.add_datab), 32'd0);
    check({tag, ":resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, ":resp_data"}, 32'(bus.resp_data), 32'd0);
    check({tag, ":resp_flags"},
          32'({bus.resp_sign, bus.resp_overflow, bus.resp_underflow}), 32'd0);
    check({tag, ":busy"}, 32'(bus.busy), 32'd0);
    check({tag, ":op_count"}, 32'(bus.op_count), 32'd0);
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input int n);
    opa[i]      = a;
    opb[i]      = b;
    ops_left[i] = n;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h0, 16'h0, 0);
    drive_reqs();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Reset in the middle of requester 1's wait phase; that operation must vanish.
    set_req(1, rand_op(), rand_op(), 1);
    repeat (4) step();
    check("mid_wait_busy_before_reset", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_wait");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four requesting continuously: 0,1,2,3,0,1 with 7-cycle spacing.
    obs_g.delete();
    obs_c.delete();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_op(), rand_op(), 2);
    run_until_idle(200);
    check("rr_grant_count", 32'(obs_g.size()), 32'd8);
    for (int k = 0; k < 6 && k < obs_g.size(); k++) begin
      check("rr_order", 32'(obs_g[k]), 32'(k % NUM_REQ));
      if (k > 0) check("rr_spacing", 32'(obs_c[k] - obs_c[k-1]), 32'(RESP_LAT));
    end

    // Requester 2: 1.0 + 2.0 = 3.0.
    set_req(2, 16'h3C00, 16'h4000, 1);
    run_until_idle(50);
    check("one_plus_two_data", 32'(bus.resp_data), 32'h4200);
    check("one_plus_two_flags",
          32'({bus.resp_sign, bus.resp_overflow, bus.resp_underflow}), 32'd0);

    // Requester 1: -1.0 + 1.0.
    set_req(1, 16'hBC00, 16'h3C00, 1);
    run_until_idle(50);
    check("neg_one_plus_one_data", 32'(bus.resp_data), 32'h0000);

    // Flag paths: requester 3 underflows (granted first), requester 0 overflows.
    set_req(3, 16'h0400, 16'h8401, 1);
    set_req(0, 16'h7BFF, 16'h7BFF, 1);
    run_until_idle(50);
    check("overflow_data", 32'(bus.resp_data), 32'h7C00);
    check("overflow_flag", 32'(bus.resp_overflow), 32'd1);

    // Back-to-back from requester 3 alone.
    obs_c.delete();
    obs_g.delete();
    set_req(3, rand_op(), rand_op(), 3);
    run_until_idle(60);
    check("b2b_grants", 32'(obs_g.size()), 32'd3);
    if (obs_c.size() >= 2) check("b2b_spacing", 32'(obs_c[1] - obs_c[0]), 32'(RESP_LAT));

    // Random request mixes with idle gaps.
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        set_req(i, rand_op(), rand_op(), int'($urandom_range(0, 3)));
      end
      run_until_idle(150);
      repeat ($urandom_range(0, 3)) step();
    end

    // op_count saturation.
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    m_count = 16'hFFFE;
    check("op_count_preload", 32'(bus.op_count), 32'hFFFE);
    set_req(0, rand_op(), rand_op(), 3);
    run_until_idle(60);
    check("op_count_saturated", 32'(bus.op_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
